decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered, parametrised instruction-decode stage for the proje5 datapath: splits an instruction word into
//  opcode/source/destination/immediate fields and issues them downstream over a valid/ready handshake.
//  Holds a register scoreboard and stalls on RAW/WAW hazards until the writeback port releases the register.
//  Sits between instruction fetch and the ALU/register-file stage.
// PARAMETERS
//  DATA_W    32  instruction and immediate width; required: DATA_W == OP_W + 3*REG_AW + IMM_W
//  OP_W      3   opcode (alu_op) field width
//  REG_AW    5   register address width; register file has 2**REG_AW entries
//  IMM_W     14  raw immediate field width
//  SIGN_EXT  1   1: sign-extend imm to DATA_W; 0: zero-extend
//  REG0_ZERO 1   1: register 0 is never marked busy and never causes a hazard
// PORTS
//  clk         in   1         clock, all state on rising edge
//  rst         in   1         synchronous, active-high reset
//  flush       in   1         drop held output and clear the entire scoreboard
//  in_valid    in   1         instr valid from fetch
//  in_ready    out  1         decode accepts instr this cycle
//  instr       in   DATA_W    {op, reg1, reg2, reg_dst, imm}, MSB first
//  out_valid   out  1         decoded bundle valid
//  out_ready   in   1         downstream accepts bundle
//  out_alu_op  out  OP_W      opcode
//  out_reg_write out 1        1 unless opcode is in the no-writeback set
//  out_reg1    out  REG_AW    source 1;  out_reg2 out REG_AW source 2
//  out_reg_dst out  REG_AW    destination
//  out_imm     out  DATA_W    extended immediate
//  wb_valid    in   1         writeback retires one register
//  wb_reg      in   REG_AW    register being retired
//  busy_vec    out  2**REG_AW scoreboard, bit n = register n pending
//  stall_cnt   out  16        saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* fields=0, busy_vec=0, stall_cnt=0. Reset wins over flush and every other input.
//  - Field positions: op=[DATA_W-1 -: OP_W], reg1 next REG_AW, reg2 next, reg_dst next, imm=[IMM_W-1:0].
//  - reg_write = (op != OP_NOWB0) && (op != OP_NOWB1); these are codes 0 and 1 with the MSBs zero-padded.
//  - busy_eff = busy_vec & ~(wb_valid ? onehot(wb_reg) : 0); a same-cycle writeback resolves the hazard.
//  - hazard = in_valid && (busy_eff[reg1] || busy_eff[reg2] || (reg_write && busy_eff[reg_dst])).
//    With REG0_ZERO=1, reg index 0 never contributes.
//  - in_ready = !hazard && (!out_valid || out_ready) && !flush. The handshake is combinational from inputs and state.
//  - Accept (in_valid && in_ready): the output register loads the decoded fields; out_valid=1 on the next cycle.
//    Latency is 1 cycle. If reg_write, busy[reg_dst] is set; the set wins over a same-cycle clear of the same register.
//  - out_valid && out_ready && no accept: out_valid=0, the fields hold their last value.
//  - out_valid && !out_ready: all out_* are stable; no accept occurs.
//  - Stall: stall_cnt +1 on each cycle with hazard && !flush; it saturates at 16'hFFFF.
//  - wb_valid for a register that is not busy is a no-op. Only one register retires per cycle.
//  - flush: next cycle out_valid=0 and busy_vec=0. The in-flight handshake is dropped. stall_cnt is kept.
//  - reset asserted mid-stall or mid-handshake: state returns to its reset values on the next edge; no partial issue.
// STRUCTURE
//  - decode_pkg: OP_NOWB0=0, OP_NOWB1=1, field-offset localparams derived from the parameters, and an
//    extend_imm function (sign/zero).
//  - Sub-module reg_scoreboard (NREGS, REG0_ZERO): set port, clear port, clear_all, busy_vec and busy_eff outputs.
//  - decode_stage holds field extraction, the hazard check, the output register and stall_cnt.
//  - Elaboration check: $error if DATA_W != OP_W + 3*REG_AW + IMM_W.
// TESTING
//  1 Basic decode, defaults: instr=32'h4110_FFFF, out_ready=1 -> next cycle out_valid=1, alu_op=2, reg1=1, reg2=2,
//    dst=3, imm=32'hFFFF_FFFF, reg_write=1, busy_vec[3]=1. With SIGN_EXT=0 -> imm=32'h0000_3FFF.
//  2 RAW stall: after test 1, present 32'h4301_0005 (reads r3) with no wb -> in_ready=0, stall_cnt increments each
//    cycle. Pulse wb_valid with wb_reg=3 -> accepted that same cycle; outputs reg1=3, dst=4, imm=5.
//  3 No-writeback opcode: op=0 with dst=7 -> reg_write=0, busy_vec[7] stays 0. A following reader of r7 issues with
//    no stall.
//  4 Backpressure: out_ready=0 for 3 cycles with a second instr valid -> outputs stable, in_ready=0, busy_vec
//    unchanged. Set out_ready=1 -> the second instr is issued the next cycle.
//  5 Flush and reset: busy r3 and r4 with out_valid=1, assert flush -> next cycle out_valid=0, busy_vec=0,
//    stall_cnt kept. Repeat with rst instead -> everything is 0, including stall_cnt.
//  6 REG0_ZERO: issue dst=0 with reg_write=1 -> busy_vec[0]=0. A following instr reading r0 issues back-to-back.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared constants and helpers for the decode stage: no-writeback opcodes,
// instruction field offsets and immediate extension.
package decode_pkg;

  localparam int OP_NOWB0 = 0;
  localparam int OP_NOWB1 = 1;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W   = 3;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_IMM_W  = 14;

  // LSB of register field idx (0 = reg1, 1 = reg2, 2 = reg_dst), fields packed MSB first after op
  function automatic int field_lsb(input int data_w, input int op_w, input int reg_aw, input int idx);
    return data_w - op_w - (idx + 1) * reg_aw;
  endfunction

  localparam int DEF_REG1_LSB = field_lsb(DEF_DATA_W, DEF_OP_W, DEF_REG_AW, 0);
  localparam int DEF_REG2_LSB = field_lsb(DEF_DATA_W, DEF_OP_W, DEF_REG_AW, 1);
  localparam int DEF_DST_LSB  = field_lsb(DEF_DATA_W, DEF_OP_W, DEF_REG_AW, 2);

  // Extends the low imm_w bits of raw to 64 bits; callers truncate to their datapath width
  function automatic logic [63:0] extend_imm(input logic [63:0] raw, input int imm_w, input logic sext);
    logic [63:0] mask;
    mask = (64'd1 << imm_w) - 64'd1;
    if (sext && raw[imm_w-1]) begin
      return (raw & mask) | ~mask;
    end
    return raw & mask;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side, issue-side and writeback signals of the decode stage.
// slave is the decode stage's view, master the surrounding pipeline's view.
interface decode_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int REG_AW = 5
);
  localparam int NREGS = 2 ** REG_AW;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] instr;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_alu_op;
  logic              out_reg_write;
  logic [REG_AW-1:0] out_reg1;
  logic [REG_AW-1:0] out_reg2;
  logic [REG_AW-1:0] out_reg_dst;
  logic [DATA_W-1:0] out_imm;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_reg;
  logic [NREGS-1:0]  busy_vec;
  logic [15:0]       stall_cnt;

  modport slave (
    input  flush, in_valid, instr, out_ready, wb_valid, wb_reg,
    output in_ready, out_valid, out_alu_op, out_reg_write, out_reg1, out_reg2,
           out_reg_dst, out_imm, busy_vec, stall_cnt
  );

  modport master (
    output flush, in_valid, instr, out_ready, wb_valid, wb_reg,
    input  in_ready, out_valid, out_alu_op, out_reg_write, out_reg1, out_reg2,
           out_reg_dst, out_imm, busy_vec, stall_cnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
// busy_eff already reflects a same-cycle writeback so hazards resolve without a bubble.
module reg_scoreboard #(
  parameter int NREGS     = 32,
  parameter int REG0_ZERO = 1,
  localparam int IDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             clear_all,
  output logic [NREGS-1:0] busy_vec,
  output logic [NREGS-1:0] busy_eff
);

  // Register 0 is hardwired free when it is the zero register
  localparam logic [NREGS-1:0] TRACK_MASK = (REG0_ZERO != 0) ? ~NREGS'(1) : '1;

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_mask
      assign set_mask[gi] = set_en && (set_idx == IDX_W'(gi));
      assign clr_mask[gi] = clr_en && (clr_idx == IDX_W'(gi));
    end
  endgenerate

  assign busy_eff = busy_reg & ~clr_mask;

  // OR-ing the set after the clear lets a new issue win over a retire of the same register
  always_comb begin
    busy_next = '0;
    if (!clear_all) begin
      busy_next = (busy_eff | set_mask) & TRACK_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: splits the instruction into fields, checks RAW/WAW hazards
// against the scoreboard and issues one bundle per accept over valid/ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OP_W      = DEF_OP_W,
  parameter int REG_AW    = DEF_REG_AW,
  parameter int IMM_W     = DEF_IMM_W,
  parameter int SIGN_EXT  = 1,
  parameter int REG0_ZERO = 1
) (
  input  logic   clk,
  input  logic   rst,
  decode_if.slave bus
);

  localparam int NREGS    = 2 ** REG_AW;
  localparam int REG1_LSB = field_lsb(DATA_W, OP_W, REG_AW, 0);
  localparam int REG2_LSB = field_lsb(DATA_W, OP_W, REG_AW, 1);
  localparam int DST_LSB  = field_lsb(DATA_W, OP_W, REG_AW, 2);

  generate
    if (DATA_W != OP_W + 3 * REG_AW + IMM_W) begin : g_width_check
      $error("decode_stage: DATA_W must equal OP_W + 3*REG_AW + IMM_W");
    end
  endgenerate

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] reg1;
  logic [REG_AW-1:0] reg2;
  logic [REG_AW-1:0] reg_dst;
  logic [IMM_W-1:0]  imm_raw;
  logic [DATA_W-1:0] imm_ext;
  logic              reg_write;

  assign op       = bus.instr[DATA_W-1 -: OP_W];
  assign reg1     = bus.instr[REG1_LSB +: REG_AW];
  assign reg2     = bus.instr[REG2_LSB +: REG_AW];
  assign reg_dst  = bus.instr[DST_LSB +: REG_AW];
  assign imm_raw  = bus.instr[IMM_W-1:0];
  assign imm_ext  = DATA_W'(extend_imm(64'(imm_raw), IMM_W, SIGN_EXT != 0));
  assign reg_write = (op != OP_W'(OP_NOWB0)) && (op != OP_W'(OP_NOWB1));

  logic [NREGS-1:0] busy_vec;
  logic [NREGS-1:0] busy_eff;
  logic             hazard;
  logic             in_ready;
  logic             accept;
  logic             out_valid_reg;

  reg_scoreboard #(
    .NREGS     (NREGS),
    .REG0_ZERO (REG0_ZERO)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (accept && reg_write),
    .set_idx   (reg_dst),
    .clr_en    (bus.wb_valid),
    .clr_idx   (bus.wb_reg),
    .clear_all (bus.flush),
    .busy_vec  (busy_vec),
    .busy_eff  (busy_eff)
  );

  // The destination only matters when the instruction will write it back (WAW)
  assign hazard = bus.in_valid &&
                  (busy_eff[reg1] || busy_eff[reg2] || (reg_write && busy_eff[reg_dst]));

  assign in_ready = !hazard && (!out_valid_reg || bus.out_ready) && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  logic [OP_W-1:0]   alu_op_reg;
  logic              reg_write_reg;
  logic [REG_AW-1:0] reg1_reg;
  logic [REG_AW-1:0] reg2_reg;
  logic [REG_AW-1:0] reg_dst_reg;
  logic [DATA_W-1:0] imm_reg;

  // Fields only move on accept, so they stay stable under backpressure and after drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      alu_op_reg    <= '0;
      reg_write_reg <= 1'b0;
      reg1_reg      <= '0;
      reg2_reg      <= '0;
      reg_dst_reg   <= '0;
      imm_reg       <= '0;
    end else if (bus.flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      alu_op_reg    <= op;
      reg_write_reg <= reg_write;
      reg1_reg      <= reg1;
      reg2_reg      <= reg2;
      reg_dst_reg   <= reg_dst;
      imm_reg       <= imm_ext;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (hazard && !bus.flush && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_reg;
  assign bus.out_alu_op    = alu_op_reg;
  assign bus.out_reg_write = reg_write_reg;
  assign bus.out_reg1      = reg1_reg;
  assign bus.out_reg2      = reg2_reg;
  assign bus.out_reg_dst   = reg_dst_reg;
  assign bus.out_imm       = imm_reg;
  assign bus.busy_vec      = busy_vec;
  assign bus.stall_cnt     = stall_cnt_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scenarios followed by randomized traffic, all checked cycle by cycle
// against a behavioural model of the decode rules kept in this bench.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  bit          m_busy [32];
  bit          m_ov;
  int          m_op, m_r1, m_r2, m_dst;
  bit          m_rw;
  logic [31:0] m_imm;
  int          m_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pend(input int r, input bit wbv, input int wbr);
    return (r != 0) && m_busy[r] && !(wbv && (wbr == r));
  endfunction

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [31:0] mk(input int op, input int r1, input int r2, input int dst, input int imm);
    logic [31:0] w;
    w = {op[2:0], r1[4:0], r2[4:0], dst[4:0], imm[13:0]};
    return w;
  endfunction

  // One clock: drive at negedge, check in_ready, advance model at posedge, check state at next negedge
  task automatic cycle(input bit r, input bit fl, input bit iv, input logic [31:0] ins,
                       input bit ordy, input bit wbv, input int wbr);
    int op, r1, r2, dst, immr;
    bit rw, hz, rdy;
    op   = int'(ins[31:29]);
    r1   = int'(ins[28:24]);
    r2   = int'(ins[23:19]);
    dst  = int'(ins[18:14]);
    immr = int'(ins[13:0]);
    rw   = op > 1;
    rst          = r;
    bus.flush    = fl;
    bus.in_valid = iv;
    bus.instr    = ins;
    bus.out_ready = ordy;
    bus.wb_valid = wbv;
    bus.wb_reg   = wbr[4:0];
    hz  = iv && (pend(r1, wbv, wbr) || pend(r2, wbv, wbr) || (rw && pend(dst, wbv, wbr)));
    rdy = !hz && (!m_ov || ordy) && !fl;
    #1;
    if (!r) chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    @(posedge clk);
    if (r) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_ov = 0; m_op = 0; m_r1 = 0; m_r2 = 0; m_dst = 0; m_rw = 0; m_imm = '0; m_stall = 0;
    end else begin
      if (hz && !fl && m_stall < 65535) m_stall++;
      if (fl) begin
        m_ov = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
      end else begin
        if (wbv) m_busy[wbr] = 0;
        if (iv && rdy) begin
          m_ov = 1; m_op = op; m_r1 = r1; m_r2 = r2; m_dst = dst; m_rw = rw;
          m_imm = (immr >= 8192) ? 32'(immr - 16384) : 32'(immr);
          if (rw && dst != 0) m_busy[dst] = 1;
        end else if (m_ov && ordy) begin
          m_ov = 0;
        end
      end
    end
    @(negedge clk);
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("alu_op", 64'(bus.out_alu_op), 64'(m_op));
    chk("reg_write", 64'(bus.out_reg_write), 64'(m_rw));
    chk("reg1", 64'(bus.out_reg1), 64'(m_r1));
    chk("reg2", 64'(bus.out_reg2), 64'(m_r2));
    chk("reg_dst", 64'(bus.out_reg_dst), 64'(m_dst));
    chk("imm", 64'(bus.out_imm), 64'(m_imm));
    chk("busy_vec", 64'(bus.busy_vec), 64'(model_busy_vec()));
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
    $display("cyc rst=%0d fl=%0d iv=%0d instr=%h ordy=%0d wb=%0d/%0d -> ov=%0d busy=%h stall=%0d",
             r, fl, iv, ins, ordy, wbv, wbr, bus.out_valid, bus.busy_vec, bus.stall_cnt);
  endtask

  initial begin
    logic [31:0] busy_snap;
    int saved_stall;
    rst = 1'b1;
    bus.flush = 0; bus.in_valid = 0; bus.instr = '0; bus.out_ready = 0; bus.wb_valid = 0; bus.wb_reg = '0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("reset_out_valid", 64'(bus.out_valid), 0);
    chk("reset_busy", 64'(bus.busy_vec), 0);

    // 1: basic decode
    cycle(0, 0, 1, 32'h4110_FFFF, 1, 0, 0);
    chk("t1_op", 64'(bus.out_alu_op), 2);
    chk("t1_reg1", 64'(bus.out_reg1), 1);
    chk("t1_reg2", 64'(bus.out_reg2), 2);
    chk("t1_dst", 64'(bus.out_reg_dst), 3);
    chk("t1_imm", 64'(bus.out_imm), 64'h0000_0000_FFFF_FFFF);
    chk("t1_busy3", 64'(bus.busy_vec[3]), 1);

    // 2: RAW stall on r3, released by a same-cycle writeback
    cycle(0, 0, 1, 32'h4301_0005, 1, 0, 0);
    chk("t2_stall1", 64'(bus.stall_cnt), 1);
    cycle(0, 0, 1, 32'h4301_0005, 1, 0, 0);
    chk("t2_stall2", 64'(bus.stall_cnt), 2);
    cycle(0, 0, 1, 32'h4301_0005, 1, 1, 3);
    chk("t2_valid", 64'(bus.out_valid), 1);
    chk("t2_reg1", 64'(bus.out_reg1), 3);
    chk("t2_dst", 64'(bus.out_reg_dst), 4);
    chk("t2_imm", 64'(bus.out_imm), 5);

    // 3: no-writeback opcode, then a reader of r7 issues without stall
    cycle(0, 0, 1, mk(0, 1, 2, 7, 0), 1, 0, 0);
    chk("t3_rw", 64'(bus.out_reg_write), 0);
    chk("t3_busy7", 64'(bus.busy_vec[7]), 0);
    cycle(0, 0, 1, mk(2, 7, 0, 5, 9), 1, 0, 0);
    chk("t3_reader_valid", 64'(bus.out_valid), 1);
    chk("t3_no_stall", 64'(bus.stall_cnt), 2);

    // 4: backpressure for 3 cycles with a second instruction waiting
    cycle(0, 0, 1, mk(3, 10, 10, 11, 1), 1, 0, 0);
    busy_snap = bus.busy_vec;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, mk(4, 8, 9, 6, 2), 0, 0, 0);
      chk("t4_hold_dst", 64'(bus.out_reg_dst), 11);
      chk("t4_hold_busy", 64'(bus.busy_vec), 64'(busy_snap));
    end
    cycle(0, 0, 1, mk(4, 8, 9, 6, 2), 1, 0, 0);
    chk("t4_issue_dst", 64'(bus.out_reg_dst), 6);

    // 5: flush keeps stall_cnt, reset clears everything
    cycle(0, 0, 1, mk(2, 1, 1, 3, 0), 0, 0, 0);
    saved_stall = int'(bus.stall_cnt);
    cycle(0, 1, 1, mk(2, 1, 1, 4, 0), 0, 0, 0);
    chk("t5_flush_valid", 64'(bus.out_valid), 0);
    chk("t5_flush_busy", 64'(bus.busy_vec), 0);
    chk("t5_flush_stall", 64'(bus.stall_cnt), 64'(saved_stall));
    cycle(0, 0, 1, mk(2, 1, 1, 3, 0), 1, 0, 0);
    cycle(0, 0, 1, mk(2, 3, 1, 4, 0), 0, 0, 0);
    cycle(1, 0, 1, mk(2, 3, 1, 4, 0), 0, 0, 0);
    chk("t5_rst_stall", 64'(bus.stall_cnt), 0);
    chk("t5_rst_busy", 64'(bus.busy_vec), 0);
    chk("t5_rst_dst", 64'(bus.out_reg_dst), 0);

    // 6: r0 is never busy, readers of r0 issue back-to-back
    cycle(0, 0, 1, mk(5, 1, 2, 0, 3), 1, 0, 0);
    chk("t6_busy0", 64'(bus.busy_vec[0]), 0);
    cycle(0, 0, 1, mk(5, 0, 0, 2, 3), 1, 0, 0);
    chk("t6_b2b_valid", 64'(bus.out_valid), 1);
    chk("t6_b2b_dst", 64'(bus.out_reg_dst), 2);

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ins;
      ins = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 16383)));
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            ins, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
